// File: rtl/draw_pkg.sv
// Shared types and constants for the draw-region framebuffer write path.
package draw_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  // Even address of the first and last pair of the draw region (counter 7296..7424, x2).
  localparam logic [ADDR_W-1:0] FIRST_ADDR_A = 14'd14592;
  localparam logic [ADDR_W-1:0] LAST_ADDR_A  = 14'd14848;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/draw_pair_writer_if.sv
// Bundle between the address counter / controller side and the pair writer.
interface draw_pair_writer_if #(
  parameter int ADDR_W = draw_pkg::ADDR_W,
  parameter int DATA_W = draw_pkg::DATA_W,
  parameter int CNT_W  = draw_pkg::CNT_W
);

  logic              start;
  logic [DATA_W-1:0] color;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;

  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] wr_addr_a;
  logic [ADDR_W-1:0] wr_addr_b;
  logic [DATA_W-1:0] wr_data_a;
  logic [DATA_W-1:0] wr_data_b;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  pair_count;

  modport master (
    output start, color, addr_a, addr_b,
    input  we_a, we_b, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b,
    input  busy, done, err, pair_count
  );

  modport slave (
    input  start, color, addr_a, addr_b,
    output we_a, we_b, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b,
    output busy, done, err, pair_count
  );

endinterface

// File: rtl/pair_checker.sv
// Combinational predicates for an incoming even/odd address pair.
module pair_checker #(
  parameter int ADDR_W = draw_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] last_addr_a,
  input  logic              first_flag,
  output logic              pair_new,
  output logic              pair_valid
);

  logic [ADDR_W-1:0] addr_a_inc;

  assign addr_a_inc = addr_a + ADDR_W'(1);

  // A stalled counter presents the same addr_a again; only the first arrival counts.
  assign pair_new = first_flag | (addr_a != last_addr_a);

  // All-ones addr_a would wrap the increment, so it is rejected explicitly.
  assign pair_valid = ~addr_a[0] & (addr_a != {ADDR_W{1'b1}}) & (addr_b == addr_a_inc);

endmodule

// File: rtl/draw_pair_writer.sv
// Turns each new even/odd address pair into one dual-port framebuffer write
// of the colour latched at start; tracks pair count, errors and completion.
//
//   state | meaning
//   IDLE  | waiting for start, no writes
//   ARMED | accepting pairs, one write per new valid pair
//   DONE  | final pair written, address changes ignored until start
module draw_pair_writer
  import draw_pkg::*;
#(
  parameter int                           ADDR_W      = draw_pkg::ADDR_W,
  parameter int                           DATA_W      = draw_pkg::DATA_W,
  parameter logic [draw_pkg::ADDR_W-1:0]  LAST_ADDR_A = draw_pkg::LAST_ADDR_A
) (
  input  logic              clk,
  input  logic              reset,
  draw_pair_writer_if.slave bus
);

  wr_state_t         state_q;
  wr_state_t         state_d;

  logic [DATA_W-1:0] color_q;
  logic [ADDR_W-1:0] last_addr_a_q;
  logic              first_flag_q;
  logic              we_q;
  logic [ADDR_W-1:0] wr_addr_a_q;
  logic [ADDR_W-1:0] wr_addr_b_q;
  logic              err_q;
  logic [CNT_W-1:0]  pair_count_q;

  logic              pair_new;
  logic              pair_valid;
  logic              do_arm;
  logic              do_write;
  logic              do_reject;

  pair_checker #(
    .ADDR_W (ADDR_W)
  ) u_pair_checker (
    .addr_a      (bus.addr_a),
    .addr_b      (bus.addr_b),
    .last_addr_a (last_addr_a_q),
    .first_flag  (first_flag_q),
    .pair_new    (pair_new),
    .pair_valid  (pair_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start takes priority in every state; in ARMED it also suppresses that cycle's write.
  always_comb begin
    state_d   = state_q;
    do_arm    = 1'b0;
    do_write  = 1'b0;
    do_reject = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          do_arm  = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (bus.start) begin
          do_arm = 1'b1;
        end else if (pair_new) begin
          if (pair_valid) begin
            do_write = 1'b1;
            if (bus.addr_a == LAST_ADDR_A) begin
              state_d = DONE;
            end
          end else begin
            do_reject = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      color_q       <= '0;
      last_addr_a_q <= '0;
      first_flag_q  <= 1'b0;
      we_q          <= 1'b0;
      wr_addr_a_q   <= '0;
      wr_addr_b_q   <= '0;
      err_q         <= 1'b0;
      pair_count_q  <= '0;
    end else begin
      we_q <= do_write;
      if (do_arm) begin
        color_q      <= bus.color;
        pair_count_q <= '0;
        err_q        <= 1'b0;
        first_flag_q <= 1'b1;
      end
      if (do_write || do_reject) begin
        last_addr_a_q <= bus.addr_a;
        first_flag_q  <= 1'b0;
      end
      if (do_write) begin
        wr_addr_a_q <= bus.addr_a;
        wr_addr_b_q <= bus.addr_b;
        if (pair_count_q != {CNT_W{1'b1}}) begin
          pair_count_q <= pair_count_q + CNT_W'(1);
        end
      end
      if (do_reject) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.we_a       = we_q;
  assign bus.we_b       = we_q;
  assign bus.wr_addr_a  = wr_addr_a_q;
  assign bus.wr_addr_b  = wr_addr_b_q;
  assign bus.wr_data_a  = color_q;
  assign bus.wr_data_b  = color_q;
  assign bus.busy       = (state_q == ARMED);
  assign bus.done       = (state_q == DONE);
  assign bus.err        = err_q;
  assign bus.pair_count = pair_count_q;

endmodule

// File: tb/tb_draw_pair_writer.sv
// Directed bench for draw_pair_writer: sweep, stall, malformed pairs, re-arm and reset.
module tb_draw_pair_writer;
  import draw_pkg::*;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  draw_pair_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus_if ();

  draw_pair_writer #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .LAST_ADDR_A (LAST_ADDR_A)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pair(input logic [13:0] a, input logic [13:0] b);
    bus_if.addr_a = a;
    bus_if.addr_b = b;
  endtask

  task automatic do_start(input logic [7:0] c);
    bus_if.start = 1'b1;
    bus_if.color = c;
    tick();
    bus_if.start = 1'b0;
    bus_if.color = 8'h00;
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.color = 8'h00;
    set_pair(14'd0, 14'd0);
    #2;
    n_checks++;
    if ({bus_if.we_a, bus_if.we_b, bus_if.wr_addr_a, bus_if.wr_addr_b, bus_if.wr_data_a,
         bus_if.wr_data_b, bus_if.busy, bus_if.done, bus_if.err, bus_if.pair_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b busy=%b done=%b err=%b cnt=%0d, expected all 0",
               bus_if.we_a, bus_if.busy, bus_if.done, bus_if.err, bus_if.pair_count);
    end
    #10;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_no_start();
    int writes = 0;
    for (int i = 0; i < 4; i++) begin
      set_pair(FIRST_ADDR_A + 14'(2 * i), FIRST_ADDR_A + 14'(2 * i + 1));
      tick();
      if (bus_if.we_a !== 1'b0 || bus_if.we_b !== 1'b0) writes++;
    end
    n_checks++;
    if (writes !== 0) begin
      n_fail++;
      $display("FAIL no_start_writes: got %0d expected 0", writes);
    end
    n_checks++;
    if (bus_if.pair_count !== 8'd0 || bus_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL no_start_state: got cnt=%0d busy=%b expected cnt=0 busy=0",
               bus_if.pair_count, bus_if.busy);
    end
  endtask

  task automatic test_full_sweep(input logic [7:0] c, input string tag);
    int          good = 0;
    int          early_done = 0;
    logic [13:0] a;
    do_start(c);
    n_checks++;
    if (bus_if.busy !== 1'b1 || bus_if.pair_count !== 8'd0 || bus_if.we_a !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_armed: got busy=%b cnt=%0d we=%b expected busy=1 cnt=0 we=0",
               tag, bus_if.busy, bus_if.pair_count, bus_if.we_a);
    end
    for (int i = 0; i < 129; i++) begin
      a = FIRST_ADDR_A + 14'(2 * i);
      set_pair(a, a + 14'd1);
      tick();
      if (bus_if.we_a === 1'b1 && bus_if.we_b === 1'b1 && bus_if.wr_addr_a === a &&
          bus_if.wr_addr_b === a + 14'd1 && bus_if.wr_data_a === c && bus_if.wr_data_b === c)
        good++;
      if (i < 128 && bus_if.done !== 1'b0) early_done++;
    end
    n_checks++;
    if (good !== 129) begin
      n_fail++;
      $display("FAIL %s_writes: got %0d correct writes expected 129", tag, good);
    end
    n_checks++;
    if (early_done !== 0) begin
      n_fail++;
      $display("FAIL %s_early_done: got done in %0d cycles expected 0", tag, early_done);
    end
    n_checks++;
    if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_with_last: got done=%b busy=%b expected done=1 busy=0",
               tag, bus_if.done, bus_if.busy);
    end
    n_checks++;
    if (bus_if.pair_count !== 8'd129) begin
      n_fail++;
      $display("FAIL %s_count: got %0d expected 129", tag, bus_if.pair_count);
    end
    tick();
    set_pair(14'd14700, 14'd14701);
    tick();
    n_checks++;
    if (bus_if.we_a !== 1'b0 || bus_if.done !== 1'b1 || bus_if.pair_count !== 8'd129) begin
      n_fail++;
      $display("FAIL %s_done_ignores: got we=%b done=%b cnt=%0d expected we=0 done=1 cnt=129",
               tag, bus_if.we_a, bus_if.done, bus_if.pair_count);
    end
  endtask

  task automatic test_restart_done();
    int writes = 0;
    set_pair(FIRST_ADDR_A, FIRST_ADDR_A + 14'd1);
    do_start(8'h3C);
    n_checks++;
    if (bus_if.pair_count !== 8'd0 || bus_if.done !== 1'b0 || bus_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_state: got cnt=%0d done=%b busy=%b expected cnt=0 done=0 busy=1",
               bus_if.pair_count, bus_if.done, bus_if.busy);
    end
    tick();
    n_checks++;
    if (bus_if.we_a !== 1'b1 || bus_if.wr_data_a !== 8'h3C || bus_if.wr_data_b !== 8'h3C ||
        bus_if.wr_addr_a !== 14'd14592 || bus_if.pair_count !== 8'd1) begin
      n_fail++;
      $display("FAIL restart_first_write: got we=%b data=%h addr=%0d cnt=%0d expected we=1 data=3c addr=14592 cnt=1",
               bus_if.we_a, bus_if.wr_data_a, bus_if.wr_addr_a, bus_if.pair_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus_if.we_a !== 1'b0) writes++;
    end
    n_checks++;
    if (writes !== 0 || bus_if.pair_count !== 8'd1) begin
      n_fail++;
      $display("FAIL held_counter: got %0d extra writes cnt=%0d expected 0 and 1",
               writes, bus_if.pair_count);
    end
  endtask

  task automatic test_stall();
    int writes = 0;
    do_start(8'h5A);
    set_pair(14'd14600, 14'd14601);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus_if.we_a === 1'b1) writes++;
    end
    n_checks++;
    if (writes !== 1 || bus_if.pair_count !== 8'd1) begin
      n_fail++;
      $display("FAIL stall_single_write: got writes=%0d cnt=%0d expected 1 and 1",
               writes, bus_if.pair_count);
    end
    set_pair(14'd14602, 14'd14603);
    tick();
    n_checks++;
    if (bus_if.we_b !== 1'b1 || bus_if.wr_addr_b !== 14'd14603 || bus_if.pair_count !== 8'd2 ||
        bus_if.wr_data_b !== 8'h5A) begin
      n_fail++;
      $display("FAIL stall_resume: got we=%b addr_b=%0d cnt=%0d data=%h expected 1 14603 2 5a",
               bus_if.we_b, bus_if.wr_addr_b, bus_if.pair_count, bus_if.wr_data_b);
    end
  endtask

  task automatic test_malformed();
    do_start(8'h11);
    set_pair(14'd14601, 14'd14602);
    tick();
    n_checks++;
    if (bus_if.we_a !== 1'b0 || bus_if.err !== 1'b1) begin
      n_fail++;
      $display("FAIL odd_addr_a: got we=%b err=%b expected we=0 err=1", bus_if.we_a, bus_if.err);
    end
    set_pair(14'd14604, 14'd14605);
    tick();
    n_checks++;
    if (bus_if.we_a !== 1'b1 || bus_if.err !== 1'b1 || bus_if.pair_count !== 8'd1) begin
      n_fail++;
      $display("FAIL err_sticky: got we=%b err=%b cnt=%0d expected we=1 err=1 cnt=1",
               bus_if.we_a, bus_if.err, bus_if.pair_count);
    end
    set_pair(14'd14606, 14'd14604);
    tick();
    n_checks++;
    if (bus_if.we_a !== 1'b0 || bus_if.err !== 1'b1 || bus_if.pair_count !== 8'd1) begin
      n_fail++;
      $display("FAIL bad_addr_b: got we=%b err=%b cnt=%0d expected we=0 err=1 cnt=1",
               bus_if.we_a, bus_if.err, bus_if.pair_count);
    end
    do_start(8'h22);
    n_checks++;
    if (bus_if.err !== 1'b0 || bus_if.pair_count !== 8'd0) begin
      n_fail++;
      $display("FAIL err_clear_on_start: got err=%b cnt=%0d expected 0 and 0",
               bus_if.err, bus_if.pair_count);
    end
  endtask

  task automatic test_rearm();
    set_pair(14'd14610, 14'd14611);
    tick();
    set_pair(14'd14620, 14'd14621);
    bus_if.start = 1'b1;
    bus_if.color = 8'h77;
    tick();
    bus_if.start = 1'b0;
    bus_if.color = 8'h00;
    n_checks++;
    if (bus_if.we_a !== 1'b0 || bus_if.pair_count !== 8'd0 || bus_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rearm_suppress: got we=%b cnt=%0d busy=%b expected we=0 cnt=0 busy=1",
               bus_if.we_a, bus_if.pair_count, bus_if.busy);
    end
    tick();
    n_checks++;
    if (bus_if.we_a !== 1'b1 || bus_if.wr_addr_a !== 14'd14620 || bus_if.wr_data_a !== 8'h77) begin
      n_fail++;
      $display("FAIL rearm_first_pair: got we=%b addr=%0d data=%h expected 1 14620 77",
               bus_if.we_a, bus_if.wr_addr_a, bus_if.wr_data_a);
    end
  endtask

  task automatic test_reset_mid();
    do_start(8'hA5);
    for (int i = 0; i < 40; i++) begin
      set_pair(FIRST_ADDR_A + 14'(2 * i), FIRST_ADDR_A + 14'(2 * i + 1));
      tick();
    end
    n_checks++;
    if (bus_if.pair_count !== 8'd40) begin
      n_fail++;
      $display("FAIL mid_count: got %0d expected 40", bus_if.pair_count);
    end
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus_if.we_a, bus_if.we_b, bus_if.wr_addr_a, bus_if.wr_addr_b, bus_if.wr_data_a,
         bus_if.wr_data_b, bus_if.busy, bus_if.done, bus_if.err, bus_if.pair_count} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got we=%b addr=%0d data=%h busy=%b cnt=%0d expected all 0",
               bus_if.we_a, bus_if.wr_addr_a, bus_if.wr_data_a, bus_if.busy, bus_if.pair_count);
    end
    #2;
    reset = 1'b1;
    set_pair(FIRST_ADDR_A + 14'd80, FIRST_ADDR_A + 14'd81);
    tick();
    n_checks++;
    if (bus_if.we_a !== 1'b0 || bus_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got we=%b busy=%b expected 0 and 0", bus_if.we_a, bus_if.busy);
    end
    test_full_sweep(8'h96, "resweep");
  endtask

  initial begin
    test_reset();
    test_no_start();
    test_full_sweep(8'hA5, "sweep");
    test_restart_done();
    test_stall();
    test_malformed();
    test_rearm();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
